// File: rtl/pcs_rx_sync.sv
// pcs_rx_sync: 1000BASE-X PCS receive synchronization.
// Takes one 10-bit code group per clock from the PMA or from loopback.
// Finds comma alignment, then keeps checking code-group validity to
// decide whether the link is synchronized. The group is forwarded with
// its even/odd tag and sync_status.
module pcs_rx_sync #(
   parameter int GOOD_CGS_LIMIT = 3
) (
   input  logic       GTX_CLK,
   input  logic       mr_main_reset,
   input  logic [9:0] PUDI,
   input  logic       signal_detect,
   output logic [9:0] SUDI,
   output logic       rx_even,
   output logic       sync_status,
   output logic       rx_disparity
);

   // Special code groups in their RD- form. The RD+ forms are the bitwise
   // complements, so a complement compare covers both.
   localparam logic [9:0] SPECIAL_CODE_K23_7    = 10'b1110101000;
   localparam logic [9:0] SPECIAL_CODE_K27_7    = 10'b1101101000;
   localparam logic [9:0] SPECIAL_CODE_K29_7    = 10'b1011101000;
   localparam logic [9:0] SPECIAL_CODE_K30_7    = 10'b0111101000;
   localparam logic [9:0] SPECIAL_CODE_K28_5_10B = 10'b0011111010;

   localparam logic [1:0] GOOD_LIMIT = 2'(GOOD_CGS_LIMIT);

   typedef enum logic [3:0] {
      LOSS_OF_SYNC,
      COMMA_DETECT_1, ACQUIRE_SYNC_1,
      COMMA_DETECT_2, ACQUIRE_SYNC_2,
      COMMA_DETECT_3,
      SYNC_ACQUIRED_1,
      SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
      SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
      SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] good_cgs;
   logic [3:0] ones;
   logic       invalid, comma, special, data, cgbad, at_limit;

   function automatic logic match(input logic [9:0] cg, input logic [9:0] code);
      return (cg == code) || (cg == ~code);
   endfunction

   // Classify the incoming group against the current running disparity.
   always_comb begin
      ones    = 4'($countones(PUDI));
      invalid = (ones < 4'd4) || (ones > 4'd6) ||
                ((ones == 4'd6) && rx_disparity) ||
                ((ones == 4'd4) && !rx_disparity);
      comma   = (PUDI[9:3] == 7'b0011111) || (PUDI[9:3] == 7'b1100000);
      special = comma ||
                match(PUDI, SPECIAL_CODE_K23_7) ||
                match(PUDI, SPECIAL_CODE_K27_7) ||
                match(PUDI, SPECIAL_CODE_K29_7) ||
                match(PUDI, SPECIAL_CODE_K30_7) ||
                match(PUDI, SPECIAL_CODE_K28_5_10B);
      data    = !invalid && !special;
      // A comma arriving while the previous group was even sits in odd position.
      cgbad   = invalid || (comma && rx_even);
      at_limit = (good_cgs == GOOD_LIMIT);
   end

   // Next-state selection; loss of signal overrides every other transition.
   always_comb begin
      state_nxt = LOSS_OF_SYNC;
      if (signal_detect) begin
         case (state)
            LOSS_OF_SYNC:     state_nxt = comma ? COMMA_DETECT_1 : LOSS_OF_SYNC;
            COMMA_DETECT_1:   state_nxt = data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1:   state_nxt = cgbad ? LOSS_OF_SYNC :
                                          comma ? COMMA_DETECT_2 : ACQUIRE_SYNC_1;
            COMMA_DETECT_2:   state_nxt = data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_2:   state_nxt = cgbad ? LOSS_OF_SYNC :
                                          comma ? COMMA_DETECT_3 : ACQUIRE_SYNC_2;
            COMMA_DETECT_3:   state_nxt = data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            SYNC_ACQUIRED_1:  state_nxt = cgbad ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_1;
            SYNC_ACQUIRED_2:  state_nxt = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
            SYNC_ACQUIRED_3:  state_nxt = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
            SYNC_ACQUIRED_4:  state_nxt = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
            SYNC_ACQUIRED_2A: state_nxt = cgbad ? SYNC_ACQUIRED_3 :
                                          at_limit ? SYNC_ACQUIRED_1 : SYNC_ACQUIRED_2A;
            SYNC_ACQUIRED_3A: state_nxt = cgbad ? SYNC_ACQUIRED_4 :
                                          at_limit ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_3A;
            SYNC_ACQUIRED_4A: state_nxt = cgbad ? LOSS_OF_SYNC :
                                          at_limit ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_4A;
            default:          state_nxt = LOSS_OF_SYNC;
         endcase
      end
   end

   // State, alignment tag, good-group counter, disparity and output registers.
   always_ff @(posedge GTX_CLK) begin
      if (mr_main_reset) begin
         state        <= LOSS_OF_SYNC;
         good_cgs     <= 2'd0;
         SUDI         <= 10'd0;
         rx_even      <= 1'b0;
         sync_status  <= 1'b0;
         rx_disparity <= 1'b0;
      end else begin
         state <= state_nxt;
         SUDI  <= PUDI;

         // Disparity follows every group, valid or not; neutral groups hold it.
         if (ones > 4'd5)      rx_disparity <= 1'b1;
         else if (ones < 4'd5) rx_disparity <= 1'b0;

         // A detected comma defines even position; otherwise just alternate.
         case (state_nxt)
            COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3: rx_even <= 1'b1;
            default:                                         rx_even <= ~rx_even;
         endcase

         // Counter restarts on entry to a degraded level and counts each
         // good group spent in the matching recovery state, entry included.
         case (state_nxt)
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4:
               good_cgs <= 2'd0;
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A:
               good_cgs <= good_cgs + 2'd1;
            default:
               good_cgs <= good_cgs;
         endcase

         case (state_nxt)
            SYNC_ACQUIRED_1,
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
            SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
            SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A: sync_status <= 1'b1;
            default:                           sync_status <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_pcs_rx_sync.sv
// tb_pcs_rx_sync: scoreboard bench for pcs_rx_sync.
// A behavioural model predicts each output group as stimulus is driven;
// the prediction is queued and compared one edge later.
module tb_pcs_rx_sync;

   logic       GTX_CLK = 1'b0;
   logic       mr_main_reset = 1'b1;
   logic [9:0] PUDI = 10'd0;
   logic       signal_detect = 1'b1;
   logic [9:0] SUDI;
   logic       rx_even, sync_status, rx_disparity;

   pcs_rx_sync #(.GOOD_CGS_LIMIT(3)) dut (
      .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .PUDI(PUDI),
      .signal_detect(signal_detect), .SUDI(SUDI), .rx_even(rx_even),
      .sync_status(sync_status), .rx_disparity(rx_disparity)
   );

   always #5 GTX_CLK = ~GTX_CLK;

   localparam logic [9:0] K_M = 10'b0011111010;  // K28.5 RD-
   localparam logic [9:0] K_P = 10'b1100000101;  // K28.5 RD+
   localparam logic [9:0] D_M = 10'b0110110101;  // D16.2 RD-
   localparam logic [9:0] D_P = 10'b1001000101;  // D16.2 RD+
   localparam logic [9:0] BAD = 10'b1111111000;  // seven ones
   localparam logic [9:0] SPC [5] = '{10'b1110101000, 10'b1101101000,
                                      10'b1011101000, 10'b0111101000, K_M};

   typedef struct packed {
      logic [9:0] sudi;
      logic       even;
      logic       sync;
      logic       rd;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Model state: mode 0=loss, 1=comma detect, 2=acquire, 3=synced.
   int m_mode = 0, m_acq = 0, m_lvl = 0, m_good = 0;
   bit m_a = 0, m_rd = 0, m_even = 0;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input logic [9:0] p, input logic sd, input logic rst);
      int   ones;
      bit   inv, cm, sp, dat, bad;
      exp_t e;
      if (rst) begin
         m_mode = 0; m_acq = 0; m_lvl = 0; m_good = 0;
         m_a = 0; m_rd = 0; m_even = 0;
         sb.push_back('0);
         return;
      end
      ones = $countones(p);
      inv  = (ones < 4) || (ones > 6) || (ones == 6 && m_rd) || (ones == 4 && !m_rd);
      cm   = (p[9:3] == 7'b0011111) || (p[9:3] == 7'b1100000);
      sp   = cm;
      foreach (SPC[i]) if (p == SPC[i] || p == ~SPC[i]) sp = 1;
      dat  = !inv && !sp;
      bad  = inv || (cm && m_even);
      if (m_mode != 0 && !sd) m_mode = 0;
      else case (m_mode)
         0: if (sd && cm) begin m_mode = 1; m_acq = 1; end
         1: if (!dat) m_mode = 0;
            else if (m_acq == 3) begin m_mode = 3; m_lvl = 1; m_a = 0; end
            else m_mode = 2;
         2: if (bad) m_mode = 0;
            else if (cm) begin m_mode = 1; m_acq++; end
         3: if (bad) begin
               if (m_lvl == 4) m_mode = 0;
               else begin m_lvl++; m_a = 0; m_good = 0; end
            end else if (m_a) begin
               if (m_good == 3) begin m_lvl--; m_a = 0; m_good = 0; end
               else m_good++;
            end else if (m_lvl > 1) begin
               m_a = 1; m_good = 1;
            end
         default: m_mode = 0;
      endcase
      m_even = (m_mode == 1) ? 1'b1 : !m_even;
      if (ones > 5) m_rd = 1;
      else if (ones < 5) m_rd = 0;
      e.sudi = p; e.even = m_even; e.sync = (m_mode == 3); e.rd = m_rd;
      sb.push_back(e);
   endtask

   task automatic cyc(input logic [9:0] p, input logic sd, input logic rst);
      exp_t e;
      @(negedge GTX_CLK);
      PUDI = p; signal_detect = sd; mr_main_reset = rst;
      model_step(p, sd, rst);
      @(posedge GTX_CLK);
      #1;
      e = sb.pop_front();
      chk("sudi", SUDI, e.sudi);
      chk("rx_even", {9'd0, rx_even}, {9'd0, e.even});
      chk("sync_status", {9'd0, sync_status}, {9'd0, e.sync});
      chk("rx_disparity", {9'd0, rx_disparity}, {9'd0, e.rd});
   endtask

   // Idle stream with commas kept in even position and disparity-correct forms.
   task automatic idle(input int n, input logic sd);
      for (int i = 0; i < n; i++) begin
         if (!m_even) cyc(m_rd ? K_P : K_M, sd, 1'b0);
         else         cyc(m_rd ? D_P : D_M, sd, 1'b0);
      end
   endtask

   task automatic bad_n(input int n);
      for (int i = 0; i < n; i++) cyc(BAD, 1'b1, 1'b0);
   endtask

   initial begin
      // Reset held for two edges while the input toggles.
      cyc(K_M, 1'b1, 1'b1);
      cyc(D_P, 1'b1, 1'b1);
      chk("rst_sudi", SUDI, 10'd0);
      chk("rst_sync", {9'd0, sync_status}, 10'd0);
      chk("rst_even", {9'd0, rx_even}, 10'd0);

      // Acquisition: sync rises on the sixth idle group.
      idle(5, 1'b1);
      chk("acq_5", {9'd0, sync_status}, 10'd0);
      idle(1, 1'b1);
      chk("acq_6", {9'd0, sync_status}, 10'd1);
      idle(4, 1'b1);

      // Single error, then four good groups back to SYNC_ACQUIRED_1.
      bad_n(1);
      chk("err1_sync", {9'd0, sync_status}, 10'd1);
      idle(4, 1'b1);
      bad_n(3);
      chk("sa1_3bad", {9'd0, sync_status}, 10'd1);
      bad_n(1);
      chk("loss_4bad", {9'd0, sync_status}, 10'd0);

      // Only three good groups: still in 2A, so three errors lose sync.
      idle(8, 1'b1);
      chk("reacq1", {9'd0, sync_status}, 10'd1);
      bad_n(1);
      idle(3, 1'b1);
      bad_n(3);
      chk("limit_edge", {9'd0, sync_status}, 10'd0);

      // Comma in odd position counts as an error.
      idle(8, 1'b1);
      chk("reacq2", {9'd0, sync_status}, 10'd1);
      if (!m_even) idle(1, 1'b1);
      cyc(m_rd ? K_P : K_M, 1'b1, 1'b0);
      chk("odd_comma", {9'd0, sync_status}, 10'd1);
      bad_n(3);
      chk("odd_comma_loss", {9'd0, sync_status}, 10'd0);

      // Signal detect dropped in sync, then held low with a clean stream.
      idle(8, 1'b1);
      chk("reacq3", {9'd0, sync_status}, 10'd1);
      idle(1, 1'b0);
      chk("sd_drop", {9'd0, sync_status}, 10'd0);
      idle(8, 1'b0);
      chk("sd_low", {9'd0, sync_status}, 10'd0);

      // Random groups and signal detect.
      idle(8, 1'b1);
      for (int i = 0; i < 40; i++)
         cyc(10'($urandom_range(0, 1023)), ($urandom_range(0, 7) != 0), 1'b0);

      // Reset while in SYNC_ACQUIRED_3A.
      cyc(K_M, 1'b1, 1'b1);
      idle(8, 1'b1);
      bad_n(2);
      idle(1, 1'b1);
      chk("sa3a_sync", {9'd0, sync_status}, 10'd1);
      cyc(K_P, 1'b1, 1'b1);
      chk("mid_rst_sudi", SUDI, 10'd0);
      chk("mid_rst_sync", {9'd0, sync_status}, 10'd0);
      chk("mid_rst_even", {9'd0, rx_even}, 10'd0);
      chk("mid_rst_rd", {9'd0, rx_disparity}, 10'd0);
      idle(7, 1'b1);
      chk("post_rst_acq", {9'd0, sync_status}, 10'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
